// File: rtl/id_stage.sv
// ============================================================================
// Module   : id_stage
// Summary  : ARM decode stage: register file, decode, condition check, RAW freeze
// Revision : 1.0
// ============================================================================
`default_nettype none

module id_stage #(
  parameter int NUM_REGS = 15,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] pc_in,
  input  logic [3:0]        status,
  input  logic              wb_wb_en,
  input  logic [3:0]        wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  input  logic              exe_wb_en,
  input  logic              mem_wb_en,
  input  logic [3:0]        exe_dest,
  input  logic [3:0]        mem_dest,
  input  logic              exe_mem_r_en,
  input  logic              forward_en,
  output logic              wb_en,
  output logic              mem_r_en,
  output logic              mem_w_en,
  output logic              b,
  output logic              s,
  output logic [3:0]        exe_cmd,
  output logic [DATA_W-1:0] val_rn,
  output logic [DATA_W-1:0] val_rm,
  output logic              imm,
  output logic [11:0]       shift_operand,
  output logic [23:0]       signed_imm,
  output logic [3:0]        dest,
  output logic [3:0]        src1,
  output logic [3:0]        src2,
  output logic [DATA_W-1:0] pc_out,
  output logic              freeze
);

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  logic [DATA_W-1:0] regs_q [0:NUM_REGS-1];

  logic [3:0] cond;
  logic [1:0] mode;
  logic [3:0] opcode;
  logic       s_bit;
  logic [3:0] rn, rd, rm;

  logic       wb_pre, mr_pre, mw_pre, b_pre, s_pre;
  logic [3:0] cmd_pre;
  logic       uses_rn, two_src;
  logic       cond_pass;
  logic       n_f, z_f, c_f, v_f;
  logic       match_exe, match_mem;

  assign cond   = instruction[31:28];
  assign mode   = instruction[27:26];
  assign opcode = instruction[24:21];
  assign s_bit  = instruction[20];
  assign rn     = instruction[19:16];
  assign rd     = instruction[15:12];
  assign rm     = instruction[3:0];
  assign {n_f, z_f, c_f, v_f} = status;

  // A WB write to index 15 is dropped; R15 is always sourced from pc_in.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= DATA_W'(i);
      end
    end else if (wb_wb_en && wb_dest != 4'hF) begin
      regs_q[wb_dest] <= wb_value;
    end
  end

  always_comb begin
    wb_pre  = 1'b0;
    mr_pre  = 1'b0;
    mw_pre  = 1'b0;
    b_pre   = 1'b0;
    s_pre   = 1'b0;
    cmd_pre = 4'b0000;
    uses_rn = 1'b1;
    case (mode)
      MODE_DP: begin
        s_pre  = s_bit;
        wb_pre = 1'b1;
        case (opcode)
          OP_MOV: begin cmd_pre = 4'b0001; uses_rn = 1'b0; end
          OP_MVN: begin cmd_pre = 4'b1001; uses_rn = 1'b0; end
          OP_ADD: cmd_pre = 4'b0010;
          OP_ADC: cmd_pre = 4'b0011;
          OP_SUB: cmd_pre = 4'b0100;
          OP_SBC: cmd_pre = 4'b0101;
          OP_AND: cmd_pre = 4'b0110;
          OP_ORR: cmd_pre = 4'b0111;
          OP_EOR: cmd_pre = 4'b1000;
          OP_CMP: begin cmd_pre = 4'b0100; wb_pre = 1'b0; end
          OP_TST: begin cmd_pre = 4'b0110; wb_pre = 1'b0; end
          default: begin wb_pre = 1'b0; s_pre = 1'b0; end
        endcase
      end
      MODE_MEM: begin
        cmd_pre = 4'b0010;
        if (s_bit) begin
          mr_pre = 1'b1;
          wb_pre = 1'b1;
        end else begin
          mw_pre = 1'b1;
        end
      end
      MODE_BR: begin
        b_pre   = 1'b1;
        uses_rn = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = !z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = !c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = !n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = !v_f;
      4'b1000: cond_pass = c_f && !z_f;
      4'b1001: cond_pass = !c_f || z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = !z_f && (n_f == v_f);
      4'b1101: cond_pass = z_f || (n_f != v_f);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Stores read Rd as their data operand, so it takes the Rm slot.
  assign src1    = rn;
  assign src2    = mw_pre ? rd : rm;
  assign two_src = !instruction[25] || mw_pre;

  always_comb begin
    val_rn = '0;
    if (src1 == 4'hF)                       val_rn = pc_in;
    else if (wb_wb_en && wb_dest == src1)   val_rn = wb_value;
    else                                    val_rn = regs_q[src1];
  end

  always_comb begin
    val_rm = '0;
    if (src2 == 4'hF)                       val_rm = pc_in;
    else if (wb_wb_en && wb_dest == src2)   val_rm = wb_value;
    else                                    val_rm = regs_q[src2];
  end

  assign match_exe = exe_wb_en && ((uses_rn && exe_dest == src1) || (two_src && exe_dest == src2));
  assign match_mem = mem_wb_en && ((uses_rn && mem_dest == src1) || (two_src && mem_dest == src2));
  assign freeze    = forward_en ? (match_exe && exe_mem_r_en) : (match_exe || match_mem);

  // Failed condition or stall turns the instruction into a bubble for ID/EX.
  always_comb begin
    {wb_en, mem_r_en, mem_w_en, b, s} = {wb_pre, mr_pre, mw_pre, b_pre, s_pre};
    if (!cond_pass || freeze) begin
      {wb_en, mem_r_en, mem_w_en, b, s} = 5'b00000;
    end
  end

  assign exe_cmd       = cmd_pre;
  assign imm           = instruction[25];
  assign shift_operand = instruction[11:0];
  assign signed_imm    = instruction[23:0];
  assign dest          = rd;
  assign pc_out        = pc_in;

endmodule

`default_nettype wire
